// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event controller: event-type codes and
// the per-channel press-classification state encoding.
package btn_evt_pkg;

    // Event type codes carried on evt_type_o. 2'b11 is never produced.
    localparam logic [1:0] EVT_SHORT  = 2'b00;
    localparam logic [1:0] EVT_LONG   = 2'b01;
    localparam logic [1:0] EVT_REPEAT = 2'b10;

    // Press-classification states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_ARM     = 3'd0,
        ST_IDLE    = 3'd1,
        ST_PRESSED = 3'd2,
        ST_HELD    = 3'd3,
        ST_REPEAT  = 3'd4
    } btn_state_e;

endpackage

// File: rtl/btn_press_fsm.sv
// One button channel: classifies a debounced level into short / long /
// repeat events and keeps a single-entry pending slot for the arbiter.
// A classification decided on edge E is held in a one-cycle post register
// and lands in the pending slot on edge E+1.
module btn_press_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int CTR_W         = 27
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_lvl,
    input  logic       grant,
    output logic       pend_valid,
    output logic [1:0] pend_type,
    output logic       post_drop
);

    // Terminal timer values; the timer is cleared on reaching them, so it
    // never wraps.
    localparam logic [CTR_W-1:0] LONG_LAST   = CTR_W'(LONG_CYCLES - 1);
    localparam logic [CTR_W-1:0] REPEAT_LAST = CTR_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_r;
    logic [CTR_W-1:0] timer_r;
    logic             post_r;
    logic [1:0]       post_type_r;
    logic             slot_v_r;
    logic [1:0]       slot_type_r;

    // Press classification FSM with hold timer and registered event post.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_ARM;
            timer_r     <= '0;
            post_r      <= 1'b0;
            post_type_r <= EVT_SHORT;
        end else begin
            post_r      <= 1'b0;
            post_type_r <= post_type_r;
            case (state_r)
                ST_ARM: begin
                    // A button held through reset must be released first.
                    if (!btn_lvl) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end else begin
                        state_r <= ST_ARM;
                    end
                end
                ST_IDLE: begin
                    if (btn_lvl) begin
                        state_r <= ST_PRESSED;
                        timer_r <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    // Release is tested first so a release on the expiry
                    // cycle still counts as a short press.
                    if (!btn_lvl) begin
                        post_r      <= 1'b1;
                        post_type_r <= EVT_SHORT;
                        state_r     <= ST_IDLE;
                        timer_r     <= '0;
                    end else if (timer_r == LONG_LAST) begin
                        post_r      <= 1'b1;
                        post_type_r <= EVT_LONG;
                        state_r     <= REPEAT_EN ? ST_REPEAT : ST_HELD;
                        timer_r     <= '0;
                    end else begin
                        timer_r     <= timer_r + CTR_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!btn_lvl) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end else begin
                        state_r <= ST_HELD;
                    end
                end
                ST_REPEAT: begin
                    // Release beats a coinciding repeat tick: no event.
                    if (!btn_lvl) begin
                        state_r <= ST_IDLE;
                        timer_r <= '0;
                    end else if (timer_r == REPEAT_LAST) begin
                        post_r      <= 1'b1;
                        post_type_r <= EVT_REPEAT;
                        timer_r     <= '0;
                    end else begin
                        timer_r     <= timer_r + CTR_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_ARM;
                    timer_r <= '0;
                end
            endcase
        end
    end

    // Pending slot: accepts a post when empty or being granted this cycle,
    // otherwise keeps the older event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_v_r    <= 1'b0;
            slot_type_r <= EVT_SHORT;
        end else if (post_r && (!slot_v_r || grant)) begin
            slot_v_r    <= 1'b1;
            slot_type_r <= post_type_r;
        end else if (grant) begin
            slot_v_r    <= 1'b0;
        end else begin
            slot_v_r    <= slot_v_r;
            slot_type_r <= slot_type_r;
        end
    end

    assign pend_valid = slot_v_r;
    assign pend_type  = slot_type_r;
    // A post that finds the slot occupied and not leaving is lost.
    assign post_drop  = post_r & slot_v_r & ~grant;

endmodule

// File: rtl/btn_event_ctrl.sv
// Button event controller top: one press FSM per channel, a round-robin
// arbiter over the pending slots and a single valid/ready output register.
module btn_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int               N_BTN         = 4,
    parameter int               LONG_CYCLES   = 100_000_000,
    parameter int               REPEAT_CYCLES = 20_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = N_BTN'(4'b0110),
    parameter int               CTR_W         = 27
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_BTN-1:0]         btn_db_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [$clog2(N_BTN)-1:0] evt_btn_o,
    output logic [1:0]               evt_type_o,
    output logic                     overflow_o
);

    localparam int IDX_W = $clog2(N_BTN);

    logic [N_BTN-1:0] slot_v_s;
    logic [1:0]       slot_type_s [N_BTN];
    logic [N_BTN-1:0] drop_s;
    logic [N_BTN-1:0] grant_s;

    logic             grant_found_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic             grant_en_s;
    logic             fire_s;

    logic             out_valid_r;
    logic [IDX_W-1:0] out_btn_r;
    logic [1:0]       out_type_r;
    logic [IDX_W-1:0] rr_r;
    logic             overflow_r;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_press_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_MASK[i]),
            .CTR_W         (CTR_W)
        ) u_fsm (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .btn_lvl    (btn_db_i[i]),
            .grant      (grant_s[i]),
            .pend_valid (slot_v_s[i]),
            .pend_type  (slot_type_s[i]),
            .post_drop  (drop_s[i])
        );
    end

    assign fire_s     = out_valid_r & evt_ready_i;
    // The output register may be refilled when empty or draining this cycle.
    assign grant_en_s = grant_found_s & (~out_valid_r | fire_s);

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!grant_found_s && slot_v_s[(int'(rr_r) + k) % N_BTN]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDX_W'((int'(rr_r) + k) % N_BTN);
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // One-hot grant back to the winning channel's slot.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (grant_en_s && (grant_idx_s == IDX_W'(i))) begin
                grant_s[i] = 1'b1;
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_r <= 1'b0;
            out_btn_r   <= '0;
            out_type_r  <= EVT_SHORT;
            rr_r        <= IDX_W'(N_BTN - 1);
        end else if (grant_en_s) begin
            out_valid_r <= 1'b1;
            out_btn_r   <= grant_idx_s;
            out_type_r  <= slot_type_s[grant_idx_s];
            rr_r        <= grant_idx_s;
        end else if (fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
            out_btn_r   <= out_btn_r;
            out_type_r  <= out_type_r;
            rr_r        <= rr_r;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_r <= 1'b0;
        end else if (|drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign evt_valid_o = out_valid_r;
    assign evt_btn_o   = out_btn_r;
    assign evt_type_o  = out_type_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl with short timing parameters.
// A behavioural model classifies each press by its hold length, then feeds
// per-channel slots, a round-robin pick and an output register; the DUT is
// compared with it every cycle, and directed literal checks pin the model.
module tb_btn_event_ctrl;

    localparam int         NB   = 4;
    localparam int         LC   = 20;
    localparam int         RC   = 5;
    localparam logic [3:0] MASK = 4'b0110;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] btn_db_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [1:0] evt_btn_o;
    logic [1:0] evt_type_o;
    logic       overflow_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    btn_event_ctrl #(
        .N_BTN         (NB),
        .LONG_CYCLES   (LC),
        .REPEAT_CYCLES (RC),
        .REPEAT_MASK   (MASK),
        .CTR_W         (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .btn_db_i    (btn_db_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_btn_o   (evt_btn_o),
        .evt_type_o  (evt_type_o),
        .overflow_o  (overflow_o)
    );

    // Model state
    bit m_armed  [NB];
    bit m_held   [NB];
    int m_start  [NB];
    bit m_post_v [NB];
    int m_post_t [NB];
    bit m_slot_v [NB];
    int m_slot_t [NB];
    int m_rr;
    int m_cyc;
    bit m_ov;
    bit m_out_v;
    int m_out_b;
    int m_out_t;

    task automatic check(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        bit fire;
        int g;
        int k;
        if (rst_i) begin
            for (int c = 0; c < NB; c++) begin
                m_armed[c] = 1'b0; m_held[c] = 1'b0; m_post_v[c] = 1'b0;
                m_slot_v[c] = 1'b0; m_slot_t[c] = 0; m_post_t[c] = 0; m_start[c] = 0;
            end
            m_rr = NB - 1; m_ov = 1'b0; m_out_v = 1'b0; m_out_b = 0; m_out_t = 0;
            m_cyc++;
            return;
        end
        fire = m_out_v && evt_ready_i;
        g = -1;
        if (!m_out_v || fire) begin
            for (int s = 1; s <= NB; s++) begin
                if (g < 0 && m_slot_v[(m_rr + s) % NB]) g = (m_rr + s) % NB;
            end
        end
        if (g >= 0) begin
            m_out_v = 1'b1; m_out_b = g; m_out_t = m_slot_t[g]; m_rr = g;
        end else if (fire) begin
            m_out_v = 1'b0;
        end
        for (int c = 0; c < NB; c++) begin
            if (m_post_v[c]) begin
                if (!m_slot_v[c] || c == g) begin
                    m_slot_v[c] = 1'b1; m_slot_t[c] = m_post_t[c];
                end else begin
                    m_ov = 1'b1;
                end
            end else if (c == g) begin
                m_slot_v[c] = 1'b0;
            end
        end
        // Classify by how many edges the button has been held.
        for (int c = 0; c < NB; c++) begin
            m_post_v[c] = 1'b0;
            if (!m_armed[c]) begin
                if (!btn_db_i[c]) m_armed[c] = 1'b1;
            end else if (!m_held[c]) begin
                if (btn_db_i[c]) begin m_held[c] = 1'b1; m_start[c] = m_cyc; end
            end else begin
                k = m_cyc - m_start[c];
                if (!btn_db_i[c]) begin
                    m_held[c] = 1'b0;
                    if (k <= LC) begin m_post_v[c] = 1'b1; m_post_t[c] = 0; end
                end else if (k == LC) begin
                    m_post_v[c] = 1'b1; m_post_t[c] = 1;
                end else if (MASK[c] && k > LC && ((k - LC) % RC) == 0) begin
                    m_post_v[c] = 1'b1; m_post_t[c] = 2;
                end
            end
        end
        m_cyc++;
    endtask

    task automatic compare_cycle();
        check("cyc_valid", {31'b0, evt_valid_o}, int'(m_out_v));
        if (m_out_v) begin
            check("cyc_btn", {30'b0, evt_btn_o}, m_out_b);
            check("cyc_type", {30'b0, evt_type_o}, m_out_t);
        end
        check("cyc_ovf", {31'b0, overflow_o}, int'(m_ov));
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        compare_cycle();
    endtask

    task automatic lit_evt(input string name, input int b, input int t);
        check({name, "_valid"}, {31'b0, evt_valid_o}, 1);
        check({name, "_btn"}, {30'b0, evt_btn_o}, b);
        check({name, "_type"}, {30'b0, evt_type_o}, t);
    endtask

    task automatic lit_idle(input string name);
        check({name, "_valid"}, {31'b0, evt_valid_o}, 0);
    endtask

    initial begin
        m_cyc = 0;
        rst_i = 1'b1; btn_db_i = 4'b0000; evt_ready_i = 1'b1;
        tick(); tick();
        check("reset_valid", {31'b0, evt_valid_o}, 0);
        check("reset_btn", {30'b0, evt_btn_o}, 0);
        check("reset_type", {30'b0, evt_type_o}, 0);
        check("reset_ovf", {31'b0, overflow_o}, 0);
        rst_i = 1'b0;
        tick(); tick();

        // Short press on channel 0: 10 cycles high.
        btn_db_i[0] = 1'b1;
        repeat (10) tick();
        btn_db_i[0] = 1'b0;
        tick(); lit_idle("short_rel");
        tick(); lit_idle("short_slot");
        tick(); lit_evt("short", 0, 0);
        tick(); lit_idle("short_once");
        repeat (3) tick();

        // Long press on channel 3, no auto-repeat.
        btn_db_i[3] = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (i == 60) btn_db_i[3] = 1'b0;
            tick();
            if (i == 21) lit_idle("long3_early");
            if (i == 22) lit_evt("long3", 3, 1);
            if (i == 27) lit_idle("long3_norep");
            if (i == 66) lit_idle("long3_rel");
        end

        // Round-robin: all four release on the same edge while stalled.
        evt_ready_i = 1'b0;
        btn_db_i = 4'b1111;
        repeat (3) tick();
        btn_db_i = 4'b0000;
        repeat (6) tick();
        lit_evt("rr0", 0, 0);
        evt_ready_i = 1'b1;
        tick(); lit_evt("rr1", 1, 0);
        tick(); lit_evt("rr2", 2, 0);
        tick(); lit_evt("rr3", 3, 0);
        tick(); lit_idle("rr_done");
        repeat (3) tick();

        // Long press with auto-repeat on channel 1, held 36 cycles.
        btn_db_i[1] = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i == 36) btn_db_i[1] = 1'b0;
            tick();
            if (i == 22) lit_evt("rep_long", 1, 1);
            if (i == 27) lit_evt("rep_1", 1, 2);
            if (i == 32) lit_evt("rep_2", 1, 2);
            if (i == 37) lit_evt("rep_3", 1, 2);
            if (i == 42) lit_idle("rep_rel");
        end

        // Overflow: channel 1 held with the consumer stalled.
        evt_ready_i = 1'b0;
        btn_db_i[1] = 1'b1;
        for (int i = 0; i < 34; i++) begin
            tick();
            if (i == 22) lit_evt("ovf_long", 1, 1);
            if (i == 30) check("ovf_before", {31'b0, overflow_o}, 0);
            if (i == 31) begin
                check("ovf_set", {31'b0, overflow_o}, 1);
                lit_evt("ovf_hold", 1, 1);
            end
        end

        // Reset mid-operation with channel 2 held and events pending.
        btn_db_i[2] = 1'b1;
        repeat (25) tick();
        rst_i = 1'b1;
        tick();
        check("rst_mid_valid", {31'b0, evt_valid_o}, 0);
        check("rst_mid_btn", {30'b0, evt_btn_o}, 0);
        check("rst_mid_type", {30'b0, evt_type_o}, 0);
        check("rst_mid_ovf", {31'b0, overflow_o}, 0);
        rst_i = 1'b0;
        evt_ready_i = 1'b1;
        repeat (40) tick();
        lit_idle("rst_held_noevt");
        btn_db_i = 4'b0000;
        tick();
        btn_db_i[2] = 1'b1;
        repeat (3) tick();
        btn_db_i[2] = 1'b0;
        tick(); tick(); tick();
        lit_evt("btn2_again", 2, 0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
